mac_arbiter: RTL and testbench
==============================

MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one MAC.
REQ-002 SHALL have parameter OP_W, default 16, width of operands a and b.
REQ-003 SHALL have parameter ACC_W, default 32, width of addend c and result.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_a  input  NUM_REQ x OP_W  multiplicand per requester.
REQ-009 SHALL have port req_b  input  NUM_REQ x OP_W  multiplier per requester.
REQ-010 SHALL have port req_c  input  NUM_REQ x ACC_W  addend per requester.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  result held for requester i.
REQ-012 SHALL have port rsp_ready  input  NUM_REQ  requester i consumes result.
REQ-013 SHALL have port rsp_result  output  NUM_REQ x ACC_W  per-requester result register.
REQ-014 SHALL have port ops_done  output  16  count of completed response handshakes, wraps at 2^16.

Function
REQ-015 SHALL treat requester i as eligible when req_valid[i]=1 and rsp_valid[i]=0 (registered value).
REQ-016 SHALL grant, combinationally, the first eligible requester searching from rr_ptr upward modulo NUM_REQ; req_ready is one-hot on the grantee, all-zero when none eligible.
REQ-017 SHALL accept at most one operation per cycle; acceptance = req_valid[i] & req_ready[i].
REQ-018 SHALL set rr_ptr to (i+1) mod NUM_REQ after accepting from i; rr_ptr unchanged on cycles with no acceptance.
REQ-019 SHALL compute result = zero-extended(a*b, unsigned, 2*OP_W bits) + c, truncated to ACC_W (wraps modulo 2^ACC_W, no saturation, no overflow flag).
REQ-020 SHALL have latency 1: operation accepted in cycle N drives rsp_valid[i]=1 and rsp_result[i] from cycle N+1.
REQ-021 SHALL hold rsp_valid[i] and rsp_result[i] stable until rsp_ready[i]=1; rsp_valid[i] clears the cycle after the handshake.
REQ-022 SHALL not re-grant requester i in its handshake cycle (eligibility uses registered rsp_valid); earliest next acceptance for i is one cycle after handshake; per-requester peak rate 1 op / 2 cycles, aggregate 1 op / cycle.
REQ-023 SHALL leave rsp_result[i] holding its last value after handshake; only a new acceptance for i overwrites it.
REQ-024 SHALL increment ops_done by the number of response handshakes in a cycle (0..NUM_REQ, simultaneous handshakes all counted).
REQ-025 SHALL ignore req_a/req_b/req_c of non-granted requesters; operands are sampled only in the acceptance cycle.
REQ-026 SHALL tolerate rsp_ready asserted with rsp_valid=0 (no effect).
REQ-027 SHALL require requesters to hold req_valid and operands stable until accepted (bench asserts this, block does not check).

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set rsp_valid=0, rsp_result=0, rr_ptr=0, ops_done=0.
REQ-029 SHALL drive req_ready all-zero during any cycle in which rst=1.
REQ-030 SHALL discard in-flight and pending results on reset mid-operation; no response for them appears after reset.

Structure
REQ-031 SHALL place NUM_REQ, OP_W, ACC_W defaults and typedef req_idx_t ($clog2(NUM_REQ) bits) in shared package mac_pkg.
REQ-032 SHALL instantiate one sub-module mac_unit: registered a*b+c with in_valid, out_valid, 1-cycle latency, shared by all requesters; arbiter routes out_valid to the granted index registered alongside.

Verification
REQ-033 Single requester: req0 a=2,b=3,c=4 -> rsp_valid[0] next cycle, rsp_result[0]=10, ops_done=1 after handshake.
REQ-034 All four valid from cycle 0 after reset (a=1..4,b=10,c=0) -> accepted in order 0,1,2,3 on consecutive cycles, results 10,20,30,40.
REQ-035 Backpressure: req1 a=5,b=7,c=1 with rsp_ready[1]=0 for 5 cycles while req_valid[1] stays 1 -> result 36 held stable, req_ready[1]=0 throughout, re-accepted one cycle after handshake.
REQ-036 Wrap: a=16'hFFFF,b=16'hFFFF,c=32'h0002_0000 -> result 32'h0000_0001.
REQ-037 Fairness: req0 and req2 continuously valid, responses always consumed -> grants alternate 0,2,0,2; neither starves.
REQ-038 Reset asserted the cycle after acceptance for req3 -> rsp_valid all zero, ops_done=0, no req3 response after release.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults and types for the multi-requester MAC arbiter.
package mac_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_OP_W    = 16;
    localparam int DEF_ACC_W   = 32;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: out_result = a*b + c one cycle after in_valid.
module mac_unit
    import mac_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [ACC_W-1:0] in_c,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_result
);

    logic [2*OP_W-1:0] product;
    logic              valid_q, valid_d;
    logic [ACC_W-1:0]  result_q, result_d;

    always_comb begin
        product  = in_a * in_b;
        valid_d  = in_valid;
        result_d = result_q;
        // Unsigned product is zero-extended or truncated to ACC_W; the add wraps.
        if (in_valid) result_d = ACC_W'(product) + in_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one registered MAC among NUM_REQ requesters,
// with a held per-requester response register and a handshake counter.
module mac_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int OP_W    = DEF_OP_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][OP_W-1:0]    req_a,
    input  logic [NUM_REQ-1:0][OP_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0][ACC_W-1:0]   req_c,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ-1:0][ACC_W-1:0]   rsp_result,
    output logic [15:0]                     ops_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    idx_t                          rr_ptr_q, rr_ptr_d;
    idx_t                          idx_q, idx_d;
    idx_t                          grant_idx;
    logic                          grant_found;
    logic                          accept;
    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]            handshake;
    logic [NUM_REQ-1:0][ACC_W-1:0] result_q, result_d;
    logic [15:0]                   ops_done_q, ops_done_d;
    logic                          unit_out_valid;
    logic [ACC_W-1:0]              unit_result;
    logic [OP_W-1:0]               sel_a, sel_b;
    logic [ACC_W-1:0]              sel_c;

    // Grant search starts at rr_ptr; a requester holding a response is not eligible.
    always_comb begin
        int cand;
        cand        = 0;
        eligible    = req_valid & ~rsp_valid;
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = idx_t'(cand);
            end
        end

        accept    = grant_found && !rst;
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        if (accept) begin
            idx_d    = grant_idx;
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + idx_t'(1);
        end

        sel_a = req_a[grant_idx];
        sel_b = req_b[grant_idx];
        sel_c = req_c[grant_idx];
    end

    mac_unit #(
        .OP_W  (OP_W),
        .ACC_W (ACC_W)
    ) u_mac_unit (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_a       (sel_a),
        .in_b       (sel_b),
        .in_c       (sel_c),
        .out_valid  (unit_out_valid),
        .out_result (unit_result)
    );

    // A fresh MAC result is presented directly in its first cycle, then held locally.
    always_comb begin
        logic land;
        land        = 1'b0;
        ops_done_d  = ops_done_q;
        rsp_valid   = '0;
        rsp_result  = '0;
        handshake   = '0;
        rsp_valid_d = '0;
        result_d    = result_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            land          = unit_out_valid && (int'(idx_q) == i);
            rsp_valid[i]  = rsp_valid_q[i] | land;
            rsp_result[i] = land ? unit_result : result_q[i];
            handshake[i]  = rsp_valid[i] & rsp_ready[i];
            rsp_valid_d[i] = rsp_valid[i] & ~rsp_ready[i];
            result_d[i]   = rsp_result[i];
            // NOTE: blocking accumulation is intended here; each iteration adds to the running sum.
            ops_done_d    = ops_done_d + 16'(handshake[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            rsp_valid_q <= '0;
            // NOTE: the result bank is reset because rsp_result is visible and must read zero after reset.
            result_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign ops_done = ops_done_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: cycle model plus per-requester result scoreboard.
module tb_mac_arbiter;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][15:0]    req_a;
    logic [N-1:0][15:0]    req_b;
    logic [N-1:0][31:0]    req_c;
    logic [N-1:0]          rsp_valid;
    logic [N-1:0]          rsp_ready;
    logic [N-1:0][31:0]    rsp_result;
    logic [15:0]           ops_done;

    mac_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] exp_q [N][$];
    int          acc_log[$];
    logic [N-1:0] cont;
    int          m_ptr;
    logic [N-1:0] m_rv;
    logic [15:0] m_ops;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: evaluate at negedge+1, update the model, release accepted
    // non-continuous requests after the rising edge.
    task automatic cycle();
        int g;
        int hs;
        int idx;
        logic [N-1:0] elig;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        #1;
        g = -1;
        if (rst) begin
            check("rdy_in_reset", req_ready, '0);
        end else begin
            elig    = req_valid & ~m_rv;
            exp_gnt = '0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && elig[idx]) g = idx;
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
            check("req_ready", req_ready, exp_gnt);
            check("rsp_valid", rsp_valid, m_rv);
            check("ops_done", ops_done, m_ops);
            hs = 0;
            for (int i = 0; i < N; i++) begin
                if (m_rv[i]) begin
                    check($sformatf("rsp_result%0d", i), rsp_result[i], exp_q[i][0]);
                    if (rsp_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        m_rv[i] = 1'b0;
                        hs++;
                    end
                end
            end
            m_ops = m_ops + 16'(hs);
            if (g >= 0) begin
                exp_q[g].push_back(32'(req_a[g]) * 32'(req_b[g]) + req_c[g]);
                m_rv[g] = 1'b1;
                m_ptr   = (g + 1) % N;
                acc_log.push_back(g);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = 0;
            m_rv  = '0;
            m_ops = '0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else if (g >= 0 && !cont[g]) begin
            req_valid[g] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        req_a[i]     = a;
        req_b[i]     = b;
        req_c[i]     = c;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = '1;
        cont      = '0;
        m_ptr     = 0;
        m_rv      = '0;
        m_ops     = '0;
        @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_ops_done", ops_done, '0);
        check("rst_rsp_result", rsp_result, '0);

        // Single requester.
        set_req(0, 16'd2, 16'd3, 32'd4);
        run(1);
        check("single_result", rsp_result[0], 32'd10);
        run(2);
        check("single_ops_done", ops_done, 16'd1);

        // All four from the first cycle after reset.
        do_reset();
        acc_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'd10, 32'd0);
        run(6);
        for (int j = 0; j < 4; j++) check($sformatf("order%0d", j), acc_log[j], j);
        check("all4_ops_done", ops_done, 16'd4);

        // Backpressure on requester 1 with req_valid held.
        cont[1] = 1'b1;
        rsp_ready[1] = 1'b0;
        set_req(1, 16'd5, 16'd7, 32'd1);
        run(1);
        check("bp_result", rsp_result[1], 32'd36);
        run(5);
        check("bp_held", rsp_result[1], 32'd36);
        rsp_ready[1] = 1'b1;
        acc_log.delete();
        run(2);
        check("bp_reaccept", acc_log.size(), 1);
        cont[1] = 1'b0;
        req_valid[1] = 1'b0;
        run(2);

        // Wrap-around of a*b+c.
        set_req(2, 16'hFFFF, 16'hFFFF, 32'h0002_0000);
        run(1);
        check("wrap_result", rsp_result[2], 32'h0000_0001);
        run(2);

        // Fairness between requesters 0 and 2.
        do_reset();
        acc_log.delete();
        cont = 4'b0101;
        set_req(0, 16'd3, 16'd3, 32'd0);
        set_req(2, 16'd4, 16'd4, 32'd1);
        run(10);
        for (int j = 0; j < 8; j++) check($sformatf("fair%0d", j), acc_log[j], (j % 2 == 0) ? 0 : 2);
        cont = '0;
        req_valid = '0;
        run(3);

        // Reset the cycle after requester 3 is accepted.
        set_req(3, 16'd9, 16'd9, 32'd9);
        run(1);
        do_reset();
        check("midrst_rsp_valid", rsp_valid, '0);
        check("midrst_ops_done", ops_done, '0);
        run(3);
        check("midrst_no_rsp", rsp_valid, '0);

        // Random traffic under random backpressure.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 16'($urandom), 16'($urandom), $urandom);
            end
            rsp_ready = 4'($urandom);
            cycle();
        end
        req_valid = '0;
        rsp_ready = '1;
        run(4);
        check("drain_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
